// File: rtl/riscv_mem_pkg.sv
// Shared types and default constants for the single-port memory arbiter.
package riscv_mem_pkg;

    // Which requester currently owns the shared memory port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_DBURST = 4;
    localparam int DEF_TIMEOUT    = 255;

    // Memory request as presented on the shared port, at the default widths.
    typedef struct packed {
        logic                          we;
        logic [DEF_DATA_WIDTH/8-1:0]   be;
        logic [DEF_ADDR_WIDTH-1:0]     addr;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/riscv_mem_timeout.sv
// Response timeout counter: counts busy cycles without a memory ack and
// flags expiry on the last allowed cycle. TIMEOUT of 0 disables expiry.
module riscv_mem_timeout #(
    parameter int TIMEOUT = riscv_mem_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;

    // Clear wins over counting; the count parks at its limit rather than wrapping.
    always_comb begin
        tcnt_d = tcnt_q;
        if (clear_i) begin
            tcnt_d = '0;
        end else if (enable_i && (tcnt_q != TW'(TIMEOUT - 1))) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign expire_o = (TIMEOUT != 0) && enable_i && (tcnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and load/store data.
// Data wins by default; a burst counter forces a fetch grant after
// MAX_DBURST consecutive data grants made while fetch is waiting.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_DBURST = DEF_MAX_DBURST,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ack,
    output logic                    if_err,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ack,
    output logic                    d_err,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int DCW = $clog2(MAX_DBURST + 1);

    typedef struct packed {
        logic                  we;
        logic [BEW-1:0]        be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } port_req_t;

    arb_state_e     state_q, state_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           mem_req_q, mem_req_d;
    port_req_t      req_q, req_d;

    logic busy;
    logic decide;
    logic expire;
    logic grant_d;
    logic grant_i;

    assign busy   = (state_q != IDLE);
    assign decide = !busy || mem_ack || expire;

    riscv_mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (decide),
        .enable_i (busy && !mem_ack),
        .expire_o (expire)
    );

    // Arbitration: a timeout drops to IDLE so mem_req falls for a cycle;
    // otherwise pick data, then fetch, then idle.
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        req_d     = req_q;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        if (decide) begin
            if (busy && expire) begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end else if (d_req && ((dcnt_q < DCW'(MAX_DBURST)) || !if_req)) begin
                grant_d     = 1'b1;
                state_d     = DBUSY;
                mem_req_d   = 1'b1;
                req_d.we    = d_we;
                req_d.be    = d_be;
                req_d.addr  = d_addr;
                req_d.wdata = d_wdata;
            end else if (if_req) begin
                grant_i     = 1'b1;
                state_d     = IBUSY;
                mem_req_d   = 1'b1;
                req_d.we    = 1'b0;
                req_d.be    = '1;
                req_d.addr  = if_addr;
                req_d.wdata = '0;
            end else begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        end
    end

    // Burst counter only tracks data grants that made a waiting fetch wait longer.
    always_comb begin
        dcnt_d = dcnt_q;
        if (!if_req || grant_i) begin
            dcnt_d = '0;
        end else if (grant_d && (dcnt_q < DCW'(MAX_DBURST))) begin
            dcnt_d = dcnt_q + DCW'(1);
        end
    end

    // State, burst count and the registered memory request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dcnt_q    <= '0;
            mem_req_q <= 1'b0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            mem_req_q <= mem_req_d;
            req_q     <= req_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = req_q.we;
    assign mem_be    = req_q.be;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;

    assign if_ack   = (state_q == IBUSY) && mem_ack;
    assign if_err   = (state_q == IBUSY) && expire;
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_ack    = (state_q == DBUSY) && mem_ack;
    assign d_err    = (state_q == DBUSY) && expire;
    assign d_rdata  = d_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter (MAX_DBURST=4, TIMEOUT=8).
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int failures = 0;

    riscv_mem_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MAX_DBURST (4),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) begin
            failures++;
            $display("[TB] FAIL reset_mem: got req=%0b we=%0b be=%h addr=%h wdata=%h, expected all 0",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if ({if_ack, if_err, d_ack, d_err} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_acks: got %b, expected 0000", {if_ack, if_err, d_ack, d_err});
        end
        reset_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        checks++;
        if ({if_ack, d_ack, if_rdata, d_rdata} !== 66'd0) begin
            failures++;
            $display("[TB] FAIL idle_stray_ack: got if_ack=%0b d_ack=%0b, expected 0", if_ack, d_ack);
        end
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1;
        if_addr = 32'h100;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_grant: got req=%0b addr=%h we=%0b, expected 1/00000100/0",
                     mem_req, mem_addr, mem_we);
        end
        tick();
        checks++;
        if (if_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_early_ack: got %0b, expected 0", if_ack);
        end
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL fetch_ack: got ack=%0b rdata=%h, expected 1/deadbeef", if_ack, if_rdata);
        end
        checks++;
        if (d_ack !== 1'b0 || d_rdata !== 32'h0 || if_err !== 1'b0 || mem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL fetch_other_path: got d_ack=%0b d_rdata=%h if_err=%0b addr=%h, expected 0/0/0/100",
                     d_ack, d_rdata, if_err, mem_addr);
        end
        if_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || if_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_release: got req=%0b ack=%0b, expected 0/0", mem_req, if_ack);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] expIf;
        expIf = 10'b10_0001_0000;
        d_we = 1'b0;
        if_addr = 32'h400;
        d_addr = 32'h800;
        if_req = 1'b1;
        d_req = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (if_ack !== expIf[i] || d_ack !== !expIf[i]) begin
                failures++;
                $display("[TB] FAIL burst_order[%0d]: got if_ack=%0b d_ack=%0b, expected if_ack=%0b",
                         i, if_ack, d_ack, expIf[i]);
            end
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== (expIf[i] ? 32'h400 : 32'h800)) begin
                failures++;
                $display("[TB] FAIL burst_port[%0d]: got req=%0b addr=%h", i, mem_req, mem_addr);
            end
            if (i == 9) begin
                if_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL burst_release: got req=%0b, expected 0", mem_req);
        end
    endtask

    task automatic test_write_hold();
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h2000;
        d_be = 4'b0011;
        d_wdata = 32'h1234;
        tick();
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_be !== 4'b0011 || mem_wdata !== 32'h1234) begin
            failures++;
            $display("[TB] FAIL write_grant: got we=%0b addr=%h be=%b wdata=%h", mem_we, mem_addr, mem_be, mem_wdata);
        end
        d_addr = 32'h3000;
        d_be = 4'b1111;
        d_wdata = 32'hFFFF;
        tick();
        checks++;
        if (mem_addr !== 32'h2000 || mem_be !== 4'b0011 || mem_wdata !== 32'h1234) begin
            failures++;
            $display("[TB] FAIL write_hold: got addr=%h be=%b wdata=%h, expected 2000/0011/1234", mem_addr, mem_be, mem_wdata);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (d_ack !== 1'b1 || if_ack !== 1'b0 || mem_addr !== 32'h2000) begin
            failures++;
            $display("[TB] FAIL write_ack: got d_ack=%0b if_ack=%0b addr=%h", d_ack, if_ack, mem_addr);
        end
        d_req = 1'b0;
        d_we = 1'b0;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        d_req = 1'b1;
        d_addr = 32'h40;
        tick();
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (d_err !== (k == 8) || if_err !== 1'b0 || mem_req !== 1'b1) begin
                failures++;
                $display("[TB] FAIL timeout_cycle[%0d]: got d_err=%0b if_err=%0b req=%0b, expected d_err=%0b",
                         k, d_err, if_err, mem_req, (k == 8));
            end
            if (k == 8) d_req = 1'b0;
            tick();
        end
        checks++;
        if (mem_req !== 1'b0 || d_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_drop: got req=%0b d_err=%0b, expected 0/0", mem_req, d_err);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (d_ack !== 1'b0 || if_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_stray: got d_ack=%0b if_ack=%0b, expected 0/0", d_ack, if_ack);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_idle: got req=%0b, expected 0", mem_req);
        end
    endtask

    task automatic test_ack_at_limit();
        d_req = 1'b1;
        d_addr = 32'h80;
        tick();
        for (int k = 1; k < 8; k++) tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hC0DE_0007;
        #1;
        checks++;
        if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hC0DE_0007) begin
            failures++;
            $display("[TB] FAIL ack_at_limit: got ack=%0b err=%0b rdata=%h, expected 1/0/c0de0007", d_ack, d_err, d_rdata);
        end
        d_req = 1'b0;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || d_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ack_at_limit_release: got req=%0b err=%0b", mem_req, d_err);
        end
    endtask

    task automatic test_reset_mid();
        if_req = 1'b1;
        if_addr = 32'h500;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            failures++;
            $display("[TB] FAIL mid_grant: got req=%0b addr=%h", mem_req, mem_addr);
        end
        reset_n = 1'b0;
        if_req = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({mem_req, mem_addr, mem_be, if_ack, if_err, d_ack, d_err} !== 41'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got req=%0b addr=%h be=%b acks=%b", mem_req, mem_addr, mem_be,
                     {if_ack, if_err, d_ack, d_err});
        end
        mem_ack = 1'b1;
        #1;
        checks++;
        if (if_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_stray_ack: got %0b, expected 0", if_ack);
        end
        tick();
        mem_ack = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h600;
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h6666_0600;
        #1;
        checks++;
        if (mem_addr !== 32'h600 || if_ack !== 1'b1 || if_rdata !== 32'h6666_0600) begin
            failures++;
            $display("[TB] FAIL mid_fresh: got addr=%h ack=%0b rdata=%h", mem_addr, if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_back_to_back();
        test_write_hold();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
